// File: rtl/bus_arbiter_pkg.sv
// Shared register-bus definitions: widths, FSM encodings and the latched transaction payload.
// Used by the arbiter, the bus multiplexer and the slaves.
package bus_arbiter_pkg;

    localparam int unsigned REG_WIDTH    = 32;
    localparam int unsigned ADDR_WIDTH   = 5;
    localparam int unsigned N_SLAVES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF  = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [REG_WIDTH-1:0]  wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog: clear/enable counter flagging the last permitted BUSY cycle.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // This cycle's increment brings the count to TIMEOUT, so the strobe has been up TIMEOUT cycles.
    assign o_expired_c = i_en && (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and single-transaction sequencer for the shared register bus.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned N_SLAVES = N_SLAVES_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_we,
    input  logic [REG_WIDTH-1:0]  m0_wdata,
    output logic [REG_WIDTH-1:0]  m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_we,
    input  logic [REG_WIDTH-1:0]  m1_wdata,
    output logic [REG_WIDTH-1:0]  m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  s_stb,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic                  s_we,
    output logic [REG_WIDTH-1:0]  s_wdata,
    input  logic [REG_WIDTH-1:0]  s_rdata,
    input  logic                  s_ack
);

    state_e                     r_state, w_state_nxt;
    logic                       r_last, w_last_nxt;
    logic                       r_gnt, w_gnt_nxt;
    bus_req_t                   r_xact, w_xact_nxt;
    logic                       r_stb, w_stb_nxt;
    logic [1:0]                 r_ack, w_ack_nxt;
    logic [1:0]                 r_err, w_err_nxt;
    logic [1:0][REG_WIDTH-1:0]  r_rdata, w_rdata_nxt;
    logic                       w_wd_clr;
    logic                       w_wd_en;
    logic                       w_expired_c;
    bus_req_t                   w_m0_xact, w_m1_xact;

    assign w_m0_xact = '{addr: m0_addr, we: m0_we, wdata: m0_wdata};
    assign w_m1_xact = '{addr: m1_addr, we: m1_we, wdata: m1_wdata};
    assign w_wd_en   = (r_state == ST_BUSY);

    bus_watchdog #(
        .TIMEOUT     (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_wd_clr),
        .i_en        (w_wd_en),
        .o_expired_c (w_expired_c)
    );

    // Next-state, grant and registered-output computation.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_gnt_nxt   = r_gnt;
        w_xact_nxt  = r_xact;
        w_stb_nxt   = 1'b0;
        w_ack_nxt   = '0;
        w_err_nxt   = '0;
        w_rdata_nxt = r_rdata;
        w_wd_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_gnt_nxt  = (m0_req && m1_req) ? ~r_last : m1_req;
                    w_last_nxt = w_gnt_nxt;
                    w_xact_nxt = w_gnt_nxt ? w_m1_xact : w_m0_xact;
                    if (32'(w_xact_nxt.addr) < N_SLAVES) begin
                        w_state_nxt = ST_BUSY;
                        w_stb_nxt   = 1'b1;
                        w_wd_clr    = 1'b1;
                    end else begin
                        // Undecoded address: fail without ever strobing the slaves.
                        w_state_nxt            = ST_DONE;
                        w_err_nxt[w_gnt_nxt]   = 1'b1;
                        w_rdata_nxt[w_gnt_nxt] = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (s_ack) begin
                    w_state_nxt        = ST_DONE;
                    w_ack_nxt[r_gnt]   = 1'b1;
                    w_rdata_nxt[r_gnt] = s_rdata;
                end else if (w_expired_c) begin
                    w_state_nxt        = ST_DONE;
                    w_err_nxt[r_gnt]   = 1'b1;
                    w_rdata_nxt[r_gnt] = '0;
                end else begin
                    w_stb_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_xact  <= '0;
            r_stb   <= 1'b0;
            r_ack   <= '0;
            r_err   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_xact  <= w_xact_nxt;
            r_stb   <= w_stb_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign s_stb    = r_stb;
    assign s_addr   = r_xact.addr;
    assign s_we     = r_xact.we;
    assign s_wdata  = r_xact.wdata;
    assign m0_rdata = r_rdata[0];
    assign m1_rdata = r_rdata[1];
    assign m0_ack   = r_ack[0];
    assign m1_ack   = r_ack[1];
    assign m0_err   = r_err[0];
    assign m1_err   = r_err[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: a transaction-level model predicts pulses and strobe windows.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int unsigned NS = N_SLAVES_DEF;
    localparam int unsigned TO = TIMEOUT_DEF;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  m0_req, m1_req;
    logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
    logic                  m0_we, m1_we;
    logic [REG_WIDTH-1:0]  m0_wdata, m1_wdata;
    logic [REG_WIDTH-1:0]  m0_rdata, m1_rdata;
    logic                  m0_ack, m1_ack, m0_err, m1_err;
    logic                  s_stb, s_we, s_ack;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [REG_WIDTH-1:0]  s_wdata, s_rdata;

    bus_arbiter #(.N_SLAVES(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_stb(s_stb), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                   mst;
        int                   cyc;
        bit                   is_err;
        logic [REG_WIDTH-1:0] rdata;
    } pulse_t;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        bit                    we;
        logic [REG_WIDTH-1:0]  wdata;
        int                    start;
        int                    len;
    } stb_t;

    pulse_t exp_q[$];
    stb_t   stb_q[$];
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state: each master's intent, bus availability and the slave's plan.
    bit                    mreq[2];
    logic [ADDR_WIDTH-1:0] maddr[2];
    bit                    mwe[2];
    logic [REG_WIDTH-1:0]  mwd[2];
    bit                    granted[2];
    int                    pulse_at[2];
    int                    next_ok[2];
    bit                    en[2];
    bit                    last_m;
    int                    bus_free;
    int                    ack_at;
    logic [REG_WIDTH-1:0]  ack_data;
    int                    busy_lo, busy_hi;
    int                    rst_at = -1;
    bit                    arm_rst = 1'b0;
    bit                    rst_fired = 1'b0;
    int                    req_pct, bad_pct, lat_mode, drop_pct, spur_pct;

    task automatic model_reset(input int free_cyc);
        for (int i = 0; i < 2; i++) begin
            mreq[i]     = 1'b0;
            granted[i]  = 1'b0;
            next_ok[i]  = free_cyc;
            maddr[i]    = '0;
            mwe[i]      = 1'b0;
            mwd[i]      = '0;
        end
        last_m   = 1'b1;
        bus_free = free_cyc;
        ack_at   = -1;
        busy_lo  = -1;
        busy_hi  = -2;
        exp_q.delete();
        stb_q.delete();
    endtask

    task automatic apply_ports();
        m0_req = mreq[0]; m0_addr = maddr[0]; m0_we = mwe[0]; m0_wdata = mwd[0];
        m1_req = mreq[1]; m1_addr = maddr[1]; m1_we = mwe[1]; m1_wdata = mwd[1];
    endtask

    task automatic drive_cycle();
        int     c, w, lat, busy, r;
        bit     c0, c1;
        pulse_t e;
        stb_t   s;
        c = cyc;
        if (c == rst_at) begin
            rst       = 1'b1;
            rst_at    = -1;
            rst_fired = 1'b1;
            model_reset(c + 1);
            s_ack     = 1'b0;
            s_rdata   = $urandom;
            apply_ports();
            return;
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (granted[i]) begin
                if (c > pulse_at[i]) begin
                    granted[i] = 1'b0;
                    mreq[i]    = 1'b0;
                    next_ok[i] = c + 1;
                end else if (mreq[i] && ($urandom_range(0, 99) < drop_pct)) begin
                    mreq[i] = 1'b0;
                end
            end else if (!mreq[i] && en[i] && (c >= next_ok[i]) && ($urandom_range(0, 99) < req_pct)) begin
                mreq[i] = 1'b1;
                if ($urandom_range(0, 99) < bad_pct)
                    maddr[i] = ADDR_WIDTH'($urandom_range(NS, (1 << ADDR_WIDTH) - 1));
                else
                    maddr[i] = ADDR_WIDTH'($urandom_range(0, NS - 1));
                mwe[i] = 1'($urandom_range(0, 1));
                mwd[i] = $urandom;
            end
        end
        if (c >= bus_free) begin
            c0 = mreq[0] && !granted[0];
            c1 = mreq[1] && !granted[1];
            if (c0 || c1) begin
                w          = (c0 && c1) ? (last_m ? 0 : 1) : (c1 ? 1 : 0);
                last_m     = 1'(w);
                granted[w] = 1'b1;
                e.mst      = w;
                if (32'(maddr[w]) >= NS) begin
                    e.cyc    = c + 1;
                    e.is_err = 1'b1;
                    e.rdata  = '0;
                end else begin
                    if (lat_mode >= 0) begin
                        lat = lat_mode;
                    end else begin
                        r = $urandom_range(0, 9);
                        if (r < 6)      lat = $urandom_range(0, 3);
                        else if (r < 8) lat = $urandom_range(TO - 2, TO);
                        else            lat = $urandom_range(TO + 1, TO + 4);
                    end
                    busy     = (lat < TO) ? lat + 1 : TO;
                    ack_at   = (lat < TO) ? c + 1 + lat : -1;
                    ack_data = $urandom;
                    e.cyc    = c + 1 + busy;
                    e.is_err = (lat >= TO);
                    e.rdata  = e.is_err ? '0 : ack_data;
                    s.addr   = maddr[w];
                    s.we     = mwe[w];
                    s.wdata  = mwd[w];
                    s.start  = c + 1;
                    s.len    = busy;
                    stb_q.push_back(s);
                    busy_lo  = c + 1;
                    busy_hi  = c + busy;
                    if (arm_rst) begin
                        rst_at  = c + 3;
                        arm_rst = 1'b0;
                    end
                end
                pulse_at[w] = e.cyc;
                exp_q.push_back(e);
                bus_free = e.cyc + 1;
            end
        end
        if (c == ack_at) begin
            s_ack   = 1'b1;
            s_rdata = ack_data;
        end else begin
            s_ack   = ((c < busy_lo) || (c > busy_hi)) && ($urandom_range(0, 99) < spur_pct);
            s_rdata = $urandom;
        end
        apply_ports();
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
            drive_cycle();
        end
    endtask

    task automatic set_knobs(input bit e0, input bit e1, input int rq, input int bd,
                             input int lt, input int dr, input int sp);
        en[0] = e0; en[1] = e1;
        req_pct = rq; bad_pct = bd; lat_mode = lt; drop_pct = dr; spur_pct = sp;
    endtask

    // Monitor: pops expected pulses when the DUT presents ack/err and tracks the strobe window.
    logic [REG_WIDTH-1:0] held[2];

    always @(negedge clk) begin : mon
        pulse_t               e;
        logic                 a, er;
        logic [REG_WIDTH-1:0] rd;
        bit                   exp_stb;
        if (rst) begin
            chk("reset_stb", 64'(s_stb), 64'(0));
            chk("reset_s_bus", 64'({s_addr, s_we}), 64'(0));
            chk("reset_s_wdata", 64'(s_wdata), 64'(0));
            chk("reset_pulses", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'(0));
            chk("reset_m0_rdata", 64'(m0_rdata), 64'(0));
            chk("reset_m1_rdata", 64'(m1_rdata), 64'(0));
            held[0] = '0;
            held[1] = '0;
        end else begin
            while ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
                chk("missed_pulse", 64'(cyc), 64'(exp_q[0].cyc));
                exp_q.delete(0);
            end
            for (int i = 0; i < 2; i++) begin
                a  = (i == 0) ? m0_ack : m1_ack;
                er = (i == 0) ? m0_err : m1_err;
                rd = (i == 0) ? m0_rdata : m1_rdata;
                chk("ack_err_exclusive", 64'(a & er), 64'(0));
                if (a || er) begin
                    chk("pulse_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("pulse_master", 64'(i), 64'(e.mst));
                        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                        chk("pulse_err", 64'(er), 64'(e.is_err));
                        chk("pulse_ack", 64'(a), 64'(!e.is_err));
                        chk("pulse_rdata", 64'(rd), 64'(e.rdata));
                        held[i] = e.rdata;
                    end
                end else begin
                    chk("rdata_hold", 64'(rd), 64'(held[i]));
                end
            end
            while ((stb_q.size() > 0) && (stb_q[0].start + stb_q[0].len <= cyc))
                stb_q.delete(0);
            exp_stb = (stb_q.size() > 0) && (stb_q[0].start <= cyc);
            chk("s_stb", 64'(s_stb), 64'(exp_stb));
            if (exp_stb && s_stb) begin
                chk("s_addr", 64'(s_addr), 64'(stb_q[0].addr));
                chk("s_we", 64'(s_we), 64'(stb_q[0].we));
                chk("s_wdata", 64'(s_wdata), 64'(stb_q[0].wdata));
            end
        end
    end

    initial begin
        rst     = 1'b1;
        s_ack   = 1'b0;
        s_rdata = '0;
        held[0] = '0;
        held[1] = '0;
        set_knobs(1'b0, 1'b0, 0, 0, 0, 0, 0);
        model_reset(0);
        apply_ports();
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset(cyc);
        // Mixed random traffic with spurious slave acks and occasional bad addresses.
        set_knobs(1'b1, 1'b1, 30, 10, -1, 10, 10);
        drive_cycle();
        run_cycles(1500);
        // Both masters hammering a zero-wait slave: strict alternation, one transaction per 3 cycles.
        set_knobs(1'b1, 1'b1, 100, 0, 0, 0, 0);
        run_cycles(60);
        // Silent slave: every transaction times out.
        set_knobs(1'b0, 1'b1, 100, 0, TO + 5, 0, 0);
        run_cycles(60);
        // Undecoded addresses only.
        set_knobs(1'b1, 1'b1, 50, 100, 0, 0, 10);
        run_cycles(40);
        // Masters frequently drop req mid-transaction.
        set_knobs(1'b1, 1'b1, 60, 0, 3, 60, 0);
        run_cycles(60);
        // Reset in the third BUSY cycle of a stalled m0 transaction, then a simultaneous request.
        set_knobs(1'b1, 1'b0, 100, 0, 99, 0, 0);
        arm_rst = 1'b1;
        for (int k = 0; k < 80 && !rst_fired; k++) run_cycles(1);
        chk("reset_fired", 64'(rst_fired), 64'(1));
        set_knobs(1'b1, 1'b1, 100, 0, 0, 0, 0);
        run_cycles(30);
        set_knobs(1'b1, 1'b1, 0, 0, 0, 0, 0);
        run_cycles(TO + 10);
        chk("pulse_queue_drained", 64'(exp_q.size()), 64'(0));
        chk("stb_queue_drained", 64'(stb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
